l_class_oc_fifo1arb2: RTL and testbench
=======================================

# l_class_OC_Fifo1Arb2

Two-requester round-robin arbiter that shares the enqueue port of one 704-bit single-entry FIFO between two producers. It owns a one-entry registered staging slot, tags each accepted word with its source, and keeps per-requester acceptance counters. It sits directly upstream of a `l_class_OC_Fifo1_OC_3` instance; `out$*` connects to that FIFO's `in$enq*`.

## Interface
- `WIDTH`, 704, payload width in bits.
- `CNTW`, 16, width of each acceptance counter.

- `CLK` input 1: single clock; all state changes on its rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `a$pending` input 1: requester A has a word to send (level; must not depend on `a$enq__RDY`).
- `a$enq__ENA` input 1: A transfers this cycle; honoured only when `a$enq__RDY`.
- `a$enq_v` input WIDTH: A payload.
- `a$enq__RDY` output 1: A granted and slot can accept.
- `b$pending`, `b$enq__ENA`, `b$enq_v`, `b$enq__RDY`: same as A, for requester B.
- `out$enq__ENA` output 1: staging slot holds a valid word.
- `out$enq_v` output WIDTH: staged payload.
- `out$src` output 1: source of staged word (0 = A, 1 = B).
- `out$enq__RDY` input 1: downstream FIFO accepts this cycle.
- `a$count`, `b$count` output CNTW: words accepted from A / B since reset, wrapping.

## Operation
- State: `full`, `data[WIDTH]`, `src`, `last` (last granted requester), `cntA`, `cntB`.
- `space = !full || out$enq__RDY`. This path is combinational from downstream RDY to upstream RDY; there is no ENA→RDY path.
- Grant: if only one of A or B is pending, that requester is granted. If both are pending, the requester other than `last` is granted. If neither is pending, nothing is granted.
- `a$enq__RDY = space && grantA`; likewise for B. At most one RDY is high in any cycle.
- An accept occurs when ENA && RDY for a requester:
  - `data` ← that requester's payload; `src` ← its id; `full` ← 1.
  - `last` ← its id; its counter increments by 1, wrapping modulo 2^CNTW.
- A drain occurs when `full && out$enq__RDY`. If there is no accept in the same cycle, `full` ← 0.
- Accept and drain in the same cycle: the new word replaces the old one and `full` stays 1.
- ENA without the matching RDY is ignored: no state change and no counter change.
- `last` changes only on an accept; pending without ENA does not rotate priority.

## Timing
- Reset values: `full`=0, `data`=0, `src`=0, `last`=1 (A wins the first tie), counters 0.
  - Resulting outputs: `out$enq__ENA`=0, `out$enq_v`=0, `out$src`=0, `a$count`=`b$count`=0.
  - A and B RDY follow the grant rule with `space`=1.
- Reset mid-operation: the staged word is discarded with no drain, and counters clear.
- Latency: an accept in cycle N makes the word visible on `out$*` in cycle N+1.
- Throughput: one word per cycle while `out$enq__RDY` stays high.
  - Both requesters continuously pending give the grant sequence A, B, A, B, …
- Downstream stall (`out$enq__RDY`=0 while `full`): both RDYs low; `data`, `src` and counters are held.
- All outputs are registered except `a$enq__RDY` and `b$enq__RDY`, which are combinational.

## Structure
- Shared package: `WIDTH`, `CNTW`, source encodings `SRC_A`=0 / `SRC_B`=1.
- Sub-module `l_class_OC_RRPick2`: combinational 2-way round-robin pick.
  - Inputs: `pending[1:0]`, `last`.
  - Output: `grant[1:0]`, one-hot or zero.
- Top level holds the staging register, the `last` register and the counters.

## Test plan
- Reset then idle: `RST`=1 for 2 cycles, then release with no pending.
  - Required: `out$enq__ENA`=0, both counts 0, both RDY 0.
- Single requester: A pending with payload 0x…01, `out$enq__RDY`=1.
  - Cycle N: `a$enq__RDY`=1.
  - Cycle N+1: `out$enq_v`=0x…01, `out$src`=0, `a$count`=1.
- Tie rotation: A and B pending every cycle for 6 cycles with downstream always ready.
  - Required: `out$src` sequence 0,1,0,1,0,1.
  - End state: `a$count`=`b$count`=3.
- Stall and hold: slot full with B word 0x…BB, `out$enq__RDY`=0 for 4 cycles while A is pending.
  - Required during stall: `a$enq__RDY`=0, `out$enq_v` held at 0x…BB.
  - On release: same-cycle refill from A; next cycle `out$src`=0.
- Protocol guard: `b$enq__ENA`=1 while `b$enq__RDY`=0.
  - Required: no change to `full`, `data` or `b$count`.
- Counter wrap and mid-flight reset: `CNTW`=4, 16 accepts from A.
  - Required: `a$count` returns to 0.
  - Then assert `RST` while `full`=1. Required: next cycle `out$enq__ENA`=0, and the first tie afterwards is granted to A.

Source files
------------

// File: rtl/l_class_oc_fifo1arb2_pkg.sv
// Shared constants for the two-requester FIFO enqueue arbiter.
package l_class_oc_fifo1arb2_pkg;

  localparam int unsigned WIDTH = 704;  // payload width
  localparam int unsigned CNTW  = 16;   // acceptance counter width

  // Source ids; also the bit position of each requester in pending/grant vectors.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/l_class_oc_fifo1arb2_rrpick2.sv
// Combinational 2-way round-robin pick: a lone requester always wins, a tie goes
// to the requester that was not granted last.
module l_class_oc_fifo1arb2_rrpick2
  import l_class_oc_fifo1arb2_pkg::*;
(
  input  logic [1:0] pending_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // Grant is one-hot or zero; bit 0 is A, bit 1 is B.
  always_comb begin
    grant_o = 2'b00;
    unique case (pending_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_i == SRC_A) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/l_class_oc_fifo1arb2.sv
// Round-robin arbiter sharing one single-entry FIFO enqueue port between two
// producers, with a registered staging slot, source tag and per-source counters.
module l_class_oc_fifo1arb2
  import l_class_oc_fifo1arb2_pkg::*;
#(
  parameter int unsigned Width = WIDTH,
  parameter int unsigned CntW  = CNTW
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             a_pending_i,
  input  logic             a_enq_ena_i,
  input  logic [Width-1:0] a_enq_v_i,
  output logic             a_enq_rdy_o,

  input  logic             b_pending_i,
  input  logic             b_enq_ena_i,
  input  logic [Width-1:0] b_enq_v_i,
  output logic             b_enq_rdy_o,

  output logic             out_enq_ena_o,
  output logic [Width-1:0] out_enq_v_o,
  output logic             out_src_o,
  input  logic             out_enq_rdy_i,

  output logic [CntW-1:0]  a_count_o,
  output logic [CntW-1:0]  b_count_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic [CntW-1:0]  cnt_a_q, cnt_a_d;
  logic [CntW-1:0]  cnt_b_q, cnt_b_d;

  logic [1:0] grant;
  logic       space;
  logic       acc_a, acc_b;

  l_class_oc_fifo1arb2_rrpick2 u_pick (
    .pending_i ({b_pending_i, a_pending_i}),
    .last_i    (last_q),
    .grant_o   (grant)
  );

  // Slot can take a word when empty or when its current word leaves this cycle;
  // deliberately independent of the requesters' ENA.
  always_comb begin
    space       = !full_q || out_enq_rdy_i;
    a_enq_rdy_o = space && grant[SRC_A];
    b_enq_rdy_o = space && grant[SRC_B];
    acc_a       = a_enq_ena_i && a_enq_rdy_o;
    acc_b       = b_enq_ena_i && b_enq_rdy_o;
  end

  // Next state: an accept overwrites the slot (even while draining), a lone drain empties it.
  always_comb begin
    full_d  = full_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (acc_a) begin
      full_d  = 1'b1;
      data_d  = a_enq_v_i;
      src_d   = SRC_A;
      last_d  = SRC_A;
      cnt_a_d = cnt_a_q + CntW'(1);
    end else if (acc_b) begin
      full_d  = 1'b1;
      data_d  = b_enq_v_i;
      src_d   = SRC_B;
      last_d  = SRC_B;
      cnt_b_d = cnt_b_q + CntW'(1);
    end else if (full_q && out_enq_rdy_i) begin
      full_d = 1'b0;
    end
  end

  // State registers; last resets to B so A wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_A;
      last_q  <= SRC_B;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign out_enq_ena_o = full_q;
  assign out_enq_v_o   = data_q;
  assign out_src_o     = src_q;
  assign a_count_o     = cnt_a_q;
  assign b_count_o     = cnt_b_q;

endmodule

// File: tb/tb_l_class_oc_fifo1arb2.sv
// Self-checking bench for the two-requester FIFO enqueue arbiter.
module tb_l_class_oc_fifo1arb2;

  localparam int unsigned W  = 704;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_pend = 1'b0, a_ena = 1'b0, b_pend = 1'b0, b_ena = 1'b0;
  logic [W-1:0]  a_v = '0, b_v = '0;
  logic          out_rdy = 1'b0;
  logic          a_rdy, b_rdy, out_ena, out_src;
  logic [W-1:0]  out_v;
  logic [CW-1:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state, tracked from the arbitration rules.
  logic         m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_src  = 1'b0;
  logic         m_last = 1'b1;
  int           m_cnt_a = 0, m_cnt_b = 0;

  l_class_oc_fifo1arb2 #(.Width(W), .CntW(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .a_pending_i   (a_pend),
    .a_enq_ena_i   (a_ena),
    .a_enq_v_i     (a_v),
    .a_enq_rdy_o   (a_rdy),
    .b_pending_i   (b_pend),
    .b_enq_ena_i   (b_ena),
    .b_enq_v_i     (b_v),
    .b_enq_rdy_o   (b_rdy),
    .out_enq_ena_o (out_ena),
    .out_enq_v_o   (out_v),
    .out_src_o     (out_src),
    .out_enq_rdy_i (out_rdy),
    .a_count_o     (a_cnt),
    .b_count_o     (b_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Expected {rdy_b, rdy_a}: who would win, gated by whether the slot has room.
  function automatic logic [1:0] exp_rdy();
    logic winner_a, winner_b;
    winner_a = a_pend && (!b_pend || m_last == 1'b1);
    winner_b = b_pend && (!a_pend || m_last == 1'b0);
    if (m_full && !out_rdy) return 2'b00;
    return {winner_b, winner_a};
  endfunction

  // Advance the reference by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    logic [1:0] r;
    r = exp_rdy();
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1; m_cnt_a = 0; m_cnt_b = 0;
    end else if (a_ena && r[0]) begin
      m_full = 1'b1; m_data = a_v; m_src = 1'b0; m_last = 1'b0;
      m_cnt_a = (m_cnt_a + 1) % (1 << CW);
    end else if (b_ena && r[1]) begin
      m_full = 1'b1; m_data = b_v; m_src = 1'b1; m_last = 1'b1;
      m_cnt_b = (m_cnt_b + 1) % (1 << CW);
    end else if (m_full && out_rdy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_pend = 1'b0; a_ena = 1'b0; b_pend = 1'b0; b_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); out_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    checks++;
    if ({out_ena, out_src, a_cnt, b_cnt, a_rdy, b_rdy} !== '0 || out_v !== '0) begin
      errors++;
      $display("FAIL reset: ena=%0b src=%0b acnt=%0d bcnt=%0d ardy=%0b brdy=%0b v_zero=%0b, want all 0",
               out_ena, out_src, a_cnt, b_cnt, a_rdy, b_rdy, out_v == '0);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] one;
    one = '0; one[0] = 1'b1;
    a_pend = 1'b1; a_ena = 1'b1; a_v = one; out_rdy = 1'b1; #1;
    checks++;
    if ({a_rdy, b_rdy} !== 2'b10) begin
      errors++; $display("FAIL single_rdy: ardy=%0b brdy=%0b want 1 0", a_rdy, b_rdy);
    end
    tick();
    idle_inputs(); #1;
    checks++;
    if (out_v !== one || out_src !== 1'b0 || a_cnt !== 4'd1 || out_ena !== 1'b1) begin
      errors++;
      $display("FAIL single_out: v_lsb=%0h src=%0b acnt=%0d ena=%0b want 1 0 1 1",
               out_v[31:0], out_src, a_cnt, out_ena);
    end
  endtask

  task automatic test_tie();
    rst = 1'b1; idle_inputs(); out_rdy = 1'b1;
    tick();
    rst = 1'b0;
    a_pend = 1'b1; b_pend = 1'b1; a_ena = 1'b1; b_ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_v = rand_word(); b_v = rand_word();
      tick();
      checks++;
      if (out_src !== 1'(i % 2) || out_v !== ((i % 2) ? b_v : a_v)) begin
        errors++; $display("FAIL tie_seq[%0d]: src=%0b want %0b", i, out_src, i % 2);
      end
    end
    idle_inputs(); #1;
    checks++;
    if (a_cnt !== 4'd3 || b_cnt !== 4'd3) begin
      errors++; $display("FAIL tie_counts: acnt=%0d bcnt=%0d want 3 3", a_cnt, b_cnt);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] bb;
    bb = '0; bb[7:0] = 8'hBB;
    out_rdy = 1'b1; idle_inputs();
    tick();  // drain anything left over
    b_pend = 1'b1; b_ena = 1'b1; b_v = bb;
    tick();
    idle_inputs(); out_rdy = 1'b0;
    a_pend = 1'b1; a_ena = 1'b1; a_v = rand_word();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || out_v !== bb || out_ena !== 1'b1
          || out_src !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ardy=%0b brdy=%0b v_lsb=%0h ena=%0b src=%0b want 0 0 bb 1 1",
                 i, a_rdy, b_rdy, out_v[7:0], out_ena, out_src);
      end
      tick();
    end
    out_rdy = 1'b1; #1;
    checks++;
    if (a_rdy !== 1'b1) begin
      errors++; $display("FAIL stall_release_rdy: ardy=%0b want 1", a_rdy);
    end
    tick();
    idle_inputs(); #1;
    checks++;
    if (out_src !== 1'b0 || out_v !== a_v || out_ena !== 1'b1) begin
      errors++; $display("FAIL stall_refill: src=%0b ena=%0b want 0 1", out_src, out_ena);
    end
  endtask

  task automatic test_guard();
    logic [W-1:0] held;
    logic [CW-1:0] bc;
    out_rdy = 1'b0; idle_inputs();
    held = out_v; bc = b_cnt;
    b_ena = 1'b1; b_v = rand_word(); #1;
    checks++;
    if (b_rdy !== 1'b0) begin
      errors++; $display("FAIL guard_rdy: brdy=%0b want 0", b_rdy);
    end
    tick(); tick();
    idle_inputs(); #1;
    checks++;
    if (out_ena !== 1'b1 || out_v !== held || b_cnt !== bc) begin
      errors++;
      $display("FAIL guard_hold: ena=%0b same_v=%0b bcnt=%0d want 1 1 %0d",
               out_ena, out_v == held, b_cnt, bc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_pend = 1'($urandom_range(0, 3) != 0);
      b_pend = 1'($urandom_range(0, 3) != 0);
      a_ena  = 1'($urandom_range(0, 1));
      b_ena  = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 3) != 0);
      a_v = rand_word(); b_v = rand_word();
      rst = 1'($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if ({b_rdy, a_rdy} !== exp_rdy() || out_ena !== m_full || out_src !== m_src
          || out_v !== m_data || a_cnt !== CW'(m_cnt_a) || b_cnt !== CW'(m_cnt_b)) begin
        errors++;
        $display("FAIL random[%0d]: rdy=%b%b ena=%0b src=%0b acnt=%0d bcnt=%0d v_ok=%0b want rdy=%b ena=%0b src=%0b acnt=%0d bcnt=%0d",
                 i, b_rdy, a_rdy, out_ena, out_src, a_cnt, b_cnt, out_v === m_data,
                 exp_rdy(), m_full, m_src, m_cnt_a, m_cnt_b);
      end
      tick();
    end
    rst = 1'b0; idle_inputs();
  endtask

  task automatic test_wrap();
    rst = 1'b1; idle_inputs(); out_rdy = 1'b1;
    tick();
    rst = 1'b0;
    a_pend = 1'b1; a_ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_v = rand_word();
      tick();
    end
    idle_inputs(); out_rdy = 1'b0; #1;
    checks++;
    if (a_cnt !== 4'd0 || out_ena !== 1'b1) begin
      errors++; $display("FAIL wrap_count: acnt=%0d ena=%0b want 0 1", a_cnt, out_ena);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++;
    if (out_ena !== 1'b0 || a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midreset: ena=%0b acnt=%0d bcnt=%0d want 0 0 0", out_ena, a_cnt, b_cnt);
    end
    a_pend = 1'b1; b_pend = 1'b1; #1;
    checks++;
    if ({a_rdy, b_rdy} !== 2'b10) begin
      errors++; $display("FAIL midreset_tie: ardy=%0b brdy=%0b want 1 0", a_rdy, b_rdy);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_guard();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
